// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Function : Iterative RV32M multiply/divide. Radix-2 shift-add and
//            restoring division over 32 cycles; divide-by-zero and signed
//            overflow complete early.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rdata1E,
  input  logic [XLEN-1:0] rdata2E,
  input  logic [4:0]      waddrE,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      waddrM
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [4:0]          r_cnt;
  logic [2:0]          r_op;
  logic                r_neg;
  logic                r_rneg;
  logic [2*XLEN-1:0]   r_a;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_b;
  logic                r_busy;
  logic                r_done;
  logic [XLEN-1:0]     r_result;
  logic [4:0]          r_waddr;

  logic                w_is_div;
  logic                w_a_sgn;
  logic                w_b_sgn;
  logic                w_a_neg;
  logic                w_b_neg;
  logic                w_div0;
  logic                w_ovf;
  logic [XLEN-1:0]     w_a_mag;
  logic [XLEN-1:0]     w_b_mag;
  logic [XLEN-1:0]     w_spec;
  logic [XLEN:0]       w_sh;
  logic [XLEN-1:0]     w_sub;
  logic                w_ge;
  logic [2*XLEN-1:0]   w_acc_nxt;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_quo;
  logic [XLEN-1:0]     w_rem;
  logic [XLEN-1:0]     w_fix;

  // Operand decode, evaluated only while IDLE accepts a request.
  always_comb begin
    w_is_div = funct3[2];
    w_a_sgn  = w_is_div ? ~funct3[0] : ((funct3 == 3'b001) || (funct3 == 3'b010));
    w_b_sgn  = w_is_div ? ~funct3[0] : (funct3 == 3'b001);
    w_a_neg  = w_a_sgn & rdata1E[XLEN-1];
    w_b_neg  = w_b_sgn & rdata2E[XLEN-1];
    w_a_mag  = w_a_neg ? -rdata1E : rdata1E;
    w_b_mag  = w_b_neg ? -rdata2E : rdata2E;
    w_div0   = w_is_div && (rdata2E == '0);
    w_ovf    = w_is_div && !funct3[0] && (rdata1E == {1'b1, {(XLEN-1){1'b0}}}) &&
               (rdata2E == '1);
    if (w_div0)
      w_spec = funct3[1] ? rdata1E : '1;
    else
      w_spec = funct3[1] ? '0 : rdata1E;  // overflow: rs1 is already the most-negative value
  end

  // One iteration step plus the sign fix-up applied on the final step.
  always_comb begin
    w_sh  = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    w_ge  = (w_sh >= {1'b0, r_b});
    w_sub = w_sh[XLEN-1:0] - r_b;
    if (r_op[2])
      w_acc_nxt = {(w_ge ? w_sub : w_sh[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};
    else
      w_acc_nxt = r_b[0] ? (r_acc + r_a) : r_acc;
    w_prod = r_neg  ? -w_acc_nxt : w_acc_nxt;
    w_quo  = r_neg  ? -w_acc_nxt[XLEN-1:0] : w_acc_nxt[XLEN-1:0];
    w_rem  = r_rneg ? -w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[2*XLEN-1:XLEN];
    if (r_op[2])
      w_fix = r_op[1] ? w_rem : w_quo;
    else
      w_fix = (r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_rneg   <= 1'b0;
      r_a      <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_waddr  <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= funct3;
            r_waddr <= waddrE;
            r_neg   <= w_a_neg ^ w_b_neg;
            r_rneg  <= w_a_neg;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_b     <= w_b_mag;
            if (w_div0 || w_ovf) begin
              r_acc   <= {{XLEN{1'b0}}, w_spec};
              r_state <= S_DONE;
            end else begin
              r_state <= S_CALC;
              if (funct3[2]) begin
                r_a   <= '0;
                r_acc <= {{XLEN{1'b0}}, w_a_mag};
              end else begin
                r_a   <= {{XLEN{1'b0}}, w_a_mag};
                r_acc <= '0;
              end
            end
          end
        end
        S_CALC: begin
          r_acc <= w_acc_nxt;
          r_a   <= {r_a[2*XLEN-2:0], 1'b0};
          r_b   <= r_op[2] ? r_b : {1'b0, r_b[XLEN-1:1]};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_result <= w_fix;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          // Early-exit results spend one extra cycle here so done lands one edge after acceptance.
          if (r_done) begin
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_done   <= 1'b1;
            r_result <= r_acc[XLEN-1:0];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign waddrM = r_waddr;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Function : Directed self-checking bench for muldiv_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] rdata1E = '0;
  logic [31:0] rdata2E = '0;
  logic [4:0]  waddrE = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  waddrM;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_res = '0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .funct3  (funct3),
    .rdata1E (rdata1E),
    .rdata2E (rdata2E),
    .waddrE  (waddrE),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .waddrM  (waddrM)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // exp_lat = negedge samples after the accepting edge until done is seen.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wa,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    funct3 = f3; rdata1E = a; rdata2E = b; waddrE = wa; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; rdata1E = $urandom; rdata2E = $urandom; waddrE = ~wa;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 60);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, result, exp);
    chk({tag, "_waddr"}, {27'd0, waddrM}, {27'd0, wa});
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    chk({tag, "_res_hold"}, result, exp);
    last_res = exp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_waddr", {27'd0, waddrM}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    run_op("mul",     3'b000, 32'd7,        32'd6,        5'd5,  32'h0000002A, 33);
    run_op("mul_neg", 3'b000, 32'hFFFFFFFD, 32'd5,        5'd6,  32'hFFFFFFF1, 33);
    run_op("mulh",    3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000000, 33);
    run_op("mulhu",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFE, 33);
    run_op("mulhsu",  3'b010, 32'hFFFFFFFF, 32'd2,        5'd9,  32'hFFFFFFFF, 33);
    run_op("div",     3'b100, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFD, 33);
    run_op("rem",     3'b110, 32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFF, 33);
    run_op("divu",    3'b101, 32'd100,      32'd7,        5'd12, 32'd14,       33);
    run_op("remu",    3'b111, 32'd100,      32'd7,        5'd13, 32'd2,        33);
    run_op("divu_z",  3'b101, 32'd5,        32'd0,        5'd14, 32'hFFFFFFFF, 2);
    run_op("rem_z",   3'b110, 32'd5,        32'd0,        5'd15, 32'd5,        2);
    run_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000, 2);
    run_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h00000000, 2);

    // Flush on the tenth CALC cycle.
    @(negedge clk);
    funct3 = 3'b101; rdata1E = 32'd1000; rdata2E = 32'd3; waddrE = 5'd20; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_done", {31'd0, done}, 32'd0);
    chk("flush_result", result, last_res);
    chk("flush_no_done", ndone, 32'd0);
    run_op("mul_after_flush", 3'b000, 32'd3, 32'd3, 5'd21, 32'd9, 33);

    // Flush and start together in IDLE: nothing accepted.
    @(negedge clk);
    funct3 = 3'b000; rdata1E = 32'd4; rdata2E = 32'd4; waddrE = 5'd22;
    start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 begin start = 1'b0; flush = 1'b0; end
    @(negedge clk);
    chk("flush_start_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("flush_start_done", {31'd0, done}, 32'd0);
    chk("flush_start_result", result, 32'd9);

    // Asynchronous reset mid-CALC.
    funct3 = 3'b101; rdata1E = 32'd100; rdata2E = 32'd7; waddrE = 5'd23; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_waddr", {27'd0, waddrM}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Start pulses while busy must be ignored.
    @(negedge clk);
    funct3 = 3'b101; rdata1E = 32'd100; rdata2E = 32'd7; waddrE = 5'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        chk("ign_result", result, 32'd14);
        chk("ign_waddr", {27'd0, waddrM}, 32'd9);
      end
      start = (i < 26) && (i % 4 == 1);
      if (start) begin
        funct3 = 3'b000; rdata1E = i; rdata2E = 32'd3; waddrE = 5'd1;
      end
    end
    start = 1'b0;
    chk("ign_done_count", ndone, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
